// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencing controller for the 5-stage rv32i core. Covers the
//   hazards that EX forwarding cannot resolve:
//     - load-use: one bubble inserted ahead of EX,
//     - branch/jump redirect: IF/ID (and ID/EX in the resolve cycle) flushed,
//       optionally for several cycles,
//     - data memory not ready: whole-pipeline freeze with a sticky watchdog.
//   Stall/flush outputs are combinational from registered state plus the
//   current-cycle inputs so they take effect in the same cycle.
//
// Parameters
//   RADDR_W      register address width
//   FLUSH_CYCLES IF/ID flush cycles per redirect (1..4)
//   MEM_TIMEOUT  MEM_WAIT cycles before mem_timeout_err is raised (2..1023)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifid_rs1/rs2, ifid_use_*   source registers of the ID instruction
//   idex_mem_read, idex_rd     EX instruction is a load, and its rd
//   branch_taken               EX resolved a taken branch / JAL / JALR
//   dmem_req, dmem_ready       MEM stage access request and completion
//   pc_stall .. exmem_stall    hold controls
//   ifid_flush, idex_flush     NOP insertion controls
//   mem_timeout_err            sticky watchdog flag
//
// Optional feature (macro PIPE_HAZARD_PERF_EN)
//   Adds perf_stall_cnt / perf_flush_cnt (32-bit, wrapping) counting cycles
//   with pc_stall=1 and ifid_flush=1 respectively.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RADDR_W      = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RADDR_W-1:0] ifid_rs1,
    input  logic [RADDR_W-1:0] ifid_rs2,
    input  logic               ifid_use_rs1,
    input  logic               ifid_use_rs2,
    input  logic               idex_mem_read,
    input  logic [RADDR_W-1:0] idex_rd,
    input  logic               branch_taken,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               idex_stall,
    output logic               exmem_stall,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               mem_timeout_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // Counter widths cover the largest legal parameter values.
    localparam logic [2:0] RCNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [9:0] WCNT_MAX  = 10'(MEM_TIMEOUT - 1);
    localparam logic [9:0] WCNT_PRE  = 10'(MEM_TIMEOUT - 2);

    // True when an enabled source register matches the load destination.
    function automatic logic src_hit(
        input logic               use_src,
        input logic [RADDR_W-1:0] src,
        input logic [RADDR_W-1:0] rd
    );
        return use_src & (src == rd);
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [9:0] wcnt_r;
    logic [9:0] wcnt_nxt_s;
    logic [2:0] rcnt_r;
    logic [2:0] rcnt_nxt_s;
    logic       err_r;
    logic       err_set_s;
    logic       lu_haz_s;
    logic       mem_busy_s;
    logic       mem_done_s;
    logic       freeze_s;

    // Hazard terms; a load to x0 never creates a dependency.
    assign lu_haz_s   = idex_mem_read & (idex_rd != {RADDR_W{1'b0}}) &
                        (src_hit(ifid_use_rs1, ifid_rs1, idex_rd) |
                         src_hit(ifid_use_rs2, ifid_rs2, idex_rd));
    assign mem_busy_s = dmem_req & ~dmem_ready;
    // dmem_ready only counts when paired with a request.
    assign mem_done_s = dmem_req & dmem_ready;

    // Freeze condition: in MEM_WAIT only a completed access releases it.
    always_comb begin
        freeze_s = 1'b0;
        case (state_r)
            ST_MEM_WAIT: freeze_s = ~mem_done_s;
            ST_RUN:      freeze_s = mem_busy_s;
            ST_REDIRECT: freeze_s = mem_busy_s;
            default:     freeze_s = mem_busy_s;
        endcase
    end

    // State register with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        rcnt_nxt_s  = rcnt_r;
        err_set_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                    wcnt_nxt_s  = 10'd0;
                end else if (branch_taken) begin
                    state_nxt_s = (FLUSH_CYCLES > 1) ? ST_REDIRECT : ST_RUN;
                    rcnt_nxt_s  = RCNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (freeze_s) begin
                    // err rises together with wcnt reaching MEM_TIMEOUT-1.
                    if (wcnt_r >= WCNT_PRE) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = 1'b0;
                    end
                    if (wcnt_r != WCNT_MAX) begin
                        wcnt_nxt_s = wcnt_r + 10'd1;
                    end else begin
                        wcnt_nxt_s = wcnt_r;
                    end
                end else begin
                    wcnt_nxt_s = 10'd0;
                    if (branch_taken) begin
                        state_nxt_s = (FLUSH_CYCLES > 1) ? ST_REDIRECT : ST_RUN;
                        rcnt_nxt_s  = RCNT_LOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_REDIRECT: begin
                if (freeze_s) begin
                    // Memory freeze in REDIRECT holds the flush count.
                    state_nxt_s = ST_REDIRECT;
                end else if (branch_taken) begin
                    state_nxt_s = (FLUSH_CYCLES > 1) ? ST_REDIRECT : ST_RUN;
                    rcnt_nxt_s  = RCNT_LOAD;
                end else if (rcnt_r <= 3'd1) begin
                    state_nxt_s = ST_RUN;
                    rcnt_nxt_s  = 3'd0;
                end else begin
                    rcnt_nxt_s  = rcnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                wcnt_nxt_s  = 10'd0;
                rcnt_nxt_s  = 3'd0;
            end
        endcase
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r <= 10'd0;
            rcnt_r <= 3'd0;
            err_r  <= 1'b0;
        end else begin
            wcnt_r <= wcnt_nxt_s;
            rcnt_r <= rcnt_nxt_s;
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign mem_timeout_err = err_r;

    // Output decode in priority order: freeze, branch, redirect, load-use.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (!rst_n) begin
            pc_stall = 1'b0;
        end else if (freeze_s) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state_r == ST_REDIRECT) begin
            // ID holds a flushed bubble here, so load-use is irrelevant.
            ifid_flush = 1'b1;
        end else if (lu_haz_s) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else begin
            pc_stall = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Free-running wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (pc_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
            if (ifid_flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end else begin
                perf_flush_cnt <= perf_flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed-vector bench. u_dut uses FLUSH_CYCLES=3, MEM_TIMEOUT=8; u_dut1
//   uses the default parameters and is checked only around single-cycle
//   redirects. Control outputs are packed as
//   {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_FREEZE = 6'b111100;
    localparam logic [5:0] C_BR     = 6'b000011;
    localparam logic [5:0] C_LU     = 6'b110001;
    localparam logic [5:0] C_RDR    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_use_rs1, ifid_use_rs2, idex_mem_read;
    logic       branch_taken, dmem_req, dmem_ready;

    logic pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
    logic mem_timeout_err;
    logic pc_stall1, ifid_stall1, idex_stall1, exmem_stall1, ifid_flush1, idex_flush1;
    logic mem_timeout_err1;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt1, perf_flush_cnt1;
`endif

    logic [5:0] ctl, ctl1;
    assign ctl  = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
    assign ctl1 = {pc_stall1, ifid_stall1, idex_stall1, exmem_stall1, ifid_flush1, idex_flush1};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RADDR_W(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mem_timeout_err(mem_timeout_err)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    pipe_hazard_ctrl u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall1), .ifid_stall(ifid_stall1), .idex_stall(idex_stall1),
        .exmem_stall(exmem_stall1), .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
        .mem_timeout_err(mem_timeout_err1)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt1), .perf_flush_cnt(perf_flush_cnt1)
`endif
    );

    // Single comparison point: counts every vector, reports miscompares.
    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        check_vec(tag, {2'b00, ctl}, {2'b00, exp});
    endtask

    task automatic chk_ctl1(input string tag, input logic [5:0] exp);
        check_vec(tag, {2'b00, ctl1}, {2'b00, exp});
    endtask

    task automatic chk_err(input string tag, input logic exp);
        check_vec(tag, {7'd0, mem_timeout_err}, {7'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
        ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0; idex_mem_read = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu();
        idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1'b1;
        ifid_rs1 = 5'd3; ifid_use_rs1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with active inputs: all controls must stay low.
        idle();
        rst_n = 1'b0;
        set_lu();
        branch_taken = 1'b1;
        dmem_req = 1'b1;
        #12;
        chk_ctl("rst_ctl", C_NONE);
        chk_err("rst_err", 1'b0);
        idle();
        #1 rst_n = 1'b1;
        tick();

        // Load-use via rs2, then hazard gone once the load leaves EX.
        set_lu();
        #1 chk_ctl("lu_rs2", C_LU);
        tick();
        idex_mem_read = 1'b0;
        #1 chk_ctl("lu_clear", C_NONE);
        tick();
        // Load-use via rs1.
        idle(); idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_use_rs1 = 1'b1;
        #1 chk_ctl("lu_rs1", C_LU);
        tick();
        // Matching register but not read by the ID instruction.
        idle(); idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1'b0;
        #1 chk_ctl("lu_nouse", C_NONE);
        tick();
        // Load to x0 never stalls.
        idle(); idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_use_rs1 = 1'b1;
        #1 chk_ctl("lu_x0", C_NONE);
        tick();

        // Redirect: 3 flush cycles on u_dut, 1 on u_dut1; load-use during REDIRECT ignored.
        idle(); branch_taken = 1'b1;
        #1 chk_ctl("rd_c0", C_BR);
        chk_ctl1("rd1_c0", C_BR);
        tick();
        idle(); set_lu();
        #1 chk_ctl("rd_c1", C_RDR);
        chk_ctl1("rd1_c1", C_LU);
        tick();
        idle();
        #1 chk_ctl("rd_c2", C_RDR);
        chk_ctl1("rd1_c2", C_NONE);
        tick();
        #1 chk_ctl("rd_c3", C_NONE);
        tick();

        // A branch inside REDIRECT reloads the flush count.
        branch_taken = 1'b1;
        #1 chk_ctl("rl_c0", C_BR);
        tick();
        #1 chk_ctl("rl_c1", C_BR);
        tick();
        branch_taken = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            #1 chk_ctl($sformatf("rl_c%0d", k), C_RDR);
            tick();
        end
        #1 chk_ctl("rl_c4", C_NONE);
        tick();

        // Memory busy inside REDIRECT freezes and holds the count.
        branch_taken = 1'b1;
        #1 chk_ctl("rf_c0", C_BR);
        tick();
        branch_taken = 1'b0; dmem_req = 1'b1;
        #1 chk_ctl("rf_c1", C_FREEZE);
        tick();
        dmem_req = 1'b0;
        #1 chk_ctl("rf_c2", C_RDR);
        tick();
        #1 chk_ctl("rf_c3", C_RDR);
        tick();
        #1 chk_ctl("rf_c4", C_NONE);
        tick();

        // Memory wait for 5 cycles, released in the ready cycle.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1 chk_ctl($sformatf("mw_c%0d", k), C_FREEZE);
            tick();
        end
        dmem_ready = 1'b1;
        #1 chk_ctl("mw_rel", C_NONE);
        chk_err("mw_err", 1'b0);
        tick();
        // Ready without a request is ignored.
        dmem_req = 1'b0;
        #1 chk_ctl("rdy_noreq", C_NONE);
        tick();

        // Branch and load-use while memory busy: freeze wins, then branch wins.
        idle(); set_lu(); branch_taken = 1'b1; dmem_req = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            #1 chk_ctl($sformatf("sim_c%0d", k), C_FREEZE);
            tick();
        end
        dmem_ready = 1'b1;
        #1 chk_ctl("sim_rel", C_BR);
        tick();
        idle();
        #1 chk_ctl("sim_r1", C_RDR);
        tick();
        #1 chk_ctl("sim_r2", C_RDR);
        tick();
        #1 chk_ctl("sim_r3", C_NONE);
        tick();

        // Timeout: MEM_TIMEOUT=8, error visible from the 9th wait cycle.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            #1 chk_ctl($sformatf("to_ctl%0d", k), C_FREEZE);
            chk_err($sformatf("to_err%0d", k), (k >= 9) ? 1'b1 : 1'b0);
            tick();
        end
        dmem_ready = 1'b1;
        #1 chk_ctl("to_rel", C_NONE);
        chk_err("to_err_rel", 1'b1);
        tick();
        idle();
        #1 chk_err("to_err_sticky", 1'b1);
        tick();
        // Async reset mid-wait clears everything immediately.
        dmem_req = 1'b1;
        #1 chk_ctl("to_w1", C_FREEZE);
        tick();
        #1 chk_ctl("to_w2", C_FREEZE);
        #1 rst_n = 1'b0;
        #1 chk_ctl("to_rst_ctl", C_NONE);
        chk_err("to_rst_err", 1'b0);
        #1 rst_n = 1'b1;
        tick();
        #1 chk_ctl("to_after_rst", C_FREEZE);
        chk_err("to_after_err", 1'b0);
        tick();
        dmem_ready = 1'b1;
        #1 chk_ctl("to_final_rel", C_NONE);
        tick();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
